// File: rtl/lzx_piso.sv
// Parallel-in / serial-out converter feeding the sequence-detector stage.
// Optional odd-parity trailer bit: define LZX_PISO_PARITY_EN to compile it in.
module lzx_piso #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef LZX_PISO_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
`ifdef LZX_PISO_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic [WIDTH-1:0] din_ord;
  logic             last_bit;
  logic             accept;

  // Reorder the word once at load time so the shifter always emits its top bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST != 0) begin : g_msb
        assign din_ord[gi] = din[gi];
      end else begin : g_lsb
        assign din_ord[gi] = din[WIDTH-1-gi];
      end
    end
  endgenerate

  assign accept = din_valid & din_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
`ifdef LZX_PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      cnt_reg    <= cnt_next;
`ifdef LZX_PISO_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    cnt_next    = cnt_reg;
`ifdef LZX_PISO_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end
      SHIFT: begin
        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
`ifdef LZX_PISO_PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`ifdef LZX_PISO_PARITY_EN
      PARITY: begin
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // din_ready is only high in IDLE or on the final bit, so a load here
    // covers both the idle start and the back-to-back case.
    if (accept) begin
      state_next = SHIFT;
      shift_next = din_ord;
      cnt_next   = '0;
`ifdef LZX_PISO_PARITY_EN
      parity_next = ~(^din);
`endif
    end
  end

  // Outputs decode registered state only; nothing here sees din or din_valid.
  always_comb begin
    last_bit   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    din_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        din_ready = 1'b1;
      end
      SHIFT: begin
        sout       = shift_reg[WIDTH-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
`ifndef LZX_PISO_PARITY_EN
        last_bit   = (cnt_reg == CNT_LAST);
`endif
        din_ready  = last_bit;
      end
`ifdef LZX_PISO_PARITY_EN
      PARITY: begin
        sout       = parity_reg;
        sout_valid = 1'b1;
        busy       = 1'b1;
        last_bit   = 1'b1;
        din_ready  = 1'b1;
      end
`endif
      default: begin
        last_bit = 1'b0;
      end
    endcase
    done = last_bit;
  end

endmodule

// File: tb/tb_lzx_piso.sv
// Directed bench for lzx_piso: one MSB-first and one LSB-first instance share stimulus.
module tb_lzx_piso;

  localparam int WIDTH = 8;
`ifdef LZX_PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;

  logic din_ready_m, sout_m, sout_valid_m, busy_m, done_m;
  logic din_ready_l, sout_l, sout_valid_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lzx_piso #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_m), .sout(sout_m), .sout_valid(sout_valid_m),
    .busy(busy_m), .done(done_m)
  );

  lzx_piso #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_valid"}, sout_valid_m, 1'b0);
    chk({tag, "_idle_sout"},  sout_m,       1'b0);
    chk({tag, "_idle_busy"},  busy_m,       1'b0);
    chk({tag, "_idle_done"},  done_m,       1'b0);
    chk({tag, "_idle_ready"}, din_ready_m,  1'b1);
  endtask

  // Called at the negedge right after the accept edge. bits lists the data
  // bits in transmit order (first bit at [7]); par is the expected parity bit.
  task automatic stream(input string tag, input logic [WIDTH-1:0] bits, input logic par,
                        input bit lsb, input bit drop_valid, input int glitch);
    logic eb;
    logic last;
    for (int i = 0; i < NBITS; i++) begin
      eb   = (i < WIDTH) ? bits[WIDTH-1-i] : par;
      last = (i == NBITS - 1);
      chk($sformatf("%s_sout%0d", tag, i),  lsb ? sout_l : sout_m, eb);
      chk($sformatf("%s_valid%0d", tag, i), lsb ? sout_valid_l : sout_valid_m, 1'b1);
      chk($sformatf("%s_busy%0d", tag, i),  lsb ? busy_l : busy_m, 1'b1);
      chk($sformatf("%s_done%0d", tag, i),  lsb ? done_l : done_m, last);
      chk($sformatf("%s_ready%0d", tag, i), lsb ? din_ready_l : din_ready_m, last);
      if (drop_valid && i == 0) din_valid = 1'b0;
      if (glitch != 0 && i + 1 == glitch) begin
        din       = '0;
        din_valid = 1'b1;
      end else if (glitch != 0 && i == glitch) begin
        din_valid = 1'b0;
      end
      @(negedge clk);
    end
    $display("word %s: %0d bits streamed", tag, NBITS);
  endtask

  initial begin
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sout",  sout_m,       1'b0);
    chk("rst_valid", sout_valid_m, 1'b0);
    chk("rst_busy",  busy_m,       1'b0);
    chk("rst_done",  done_m,       1'b0);
    chk("rst_ready", din_ready_m,  1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // 8'hA5 MSB-first; odd parity of four ones is 1
    din = 8'hA5; din_valid = 1'b1;
    @(negedge clk);
    stream("a5", 8'b10100101, 1'b1, 1'b0, 1'b1, 0);
    chk_idle("a5");

    // 8'h05 LSB-first -> 1,0,1,0,0,0,0,0
    din = 8'h05; din_valid = 1'b1;
    @(negedge clk);
    stream("lsb05", 8'b10100000, 1'b1, 1'b1, 1'b1, 0);
    chk("lsb05_idle_valid", sout_valid_l, 1'b0);
    chk("lsb05_idle_ready", din_ready_l,  1'b1);

    // Back-to-back: FF then 00 with din_valid held high
    din = 8'hFF; din_valid = 1'b1;
    @(negedge clk);
    din = 8'h00;
    stream("b2b_ff", 8'hFF, 1'b1, 1'b0, 1'b0, 0);
    stream("b2b_00", 8'h00, 1'b1, 1'b0, 1'b1, 0);
    chk_idle("b2b");

    // din_valid pulse with 8'h00 during cycle 4 of word A5 is ignored
    din = 8'hA5; din_valid = 1'b1;
    @(negedge clk);
    stream("glitch", 8'b10100101, 1'b1, 1'b0, 1'b1, 4);
    chk_idle("glitch");

    // Reset asserted in cycle 5 of word C3 aborts it
    din = 8'hC3; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy_m, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_sout",  sout_m,       1'b0);
    chk("abort_valid", sout_valid_m, 1'b0);
    chk("abort_busy",  busy_m,       1'b0);
    chk("abort_done",  done_m,       1'b0);
    chk("abort_ready", din_ready_m,  1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("abort_release");
    @(negedge clk);
    chk_idle("abort_residual");
    din = 8'h3C; din_valid = 1'b1;
    @(negedge clk);
    stream("after_abort", 8'b00111100, 1'b1, 1'b0, 1'b1, 0);
    chk_idle("after_abort");

`ifdef LZX_PISO_PARITY_EN
    // Three ones -> parity 0; two ones -> parity 1
    din = 8'h07; din_valid = 1'b1;
    @(negedge clk);
    stream("par07", 8'b00000111, 1'b0, 1'b0, 1'b1, 0);
    chk_idle("par07");
    din = 8'h03; din_valid = 1'b1;
    @(negedge clk);
    stream("par03", 8'b00000011, 1'b1, 1'b0, 1'b1, 0);
    chk_idle("par03");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzx_piso.md
LZX_PISO -- requirements
Module: lzx_piso

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL have one asynchronous active-low reset; it serialises parallel words into the single-bit stream consumed by the sequence-detector stage.
REQ-002 Parameter: WIDTH, 8, number of data bits per word (legal range 2..32).
REQ-003 Parameter: MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous reset, active low.
REQ-006 Port: din  input  WIDTH  parallel word to serialise.
REQ-007 Port: din_valid  input  1  din holds a word to transfer.
REQ-008 Port: din_ready  output  1  block can accept a word this cycle.
REQ-009 Port: sout  output  1  serial bit; connects directly to the detector's serial input.
REQ-010 Port: sout_valid  output  1  sout carries a data or parity bit this cycle.
REQ-011 Port: busy  output  1  a word is being shifted out.
REQ-012 Port: done  output  1  one-cycle pulse during the final bit of a word.

Function
REQ-013 A word SHALL be accepted on a rising edge where din_valid and din_ready are both 1; din SHALL be captured into an internal shift register.
REQ-014 The state machine SHALL have the states IDLE and SHIFT, plus PARITY when the configuration feature is compiled in; illegal encodings SHALL return to IDLE.
REQ-015 IDLE transitions: on accept -> SHIFT; otherwise remain in IDLE; din_ready=1, sout=0, sout_valid=0, busy=0.
REQ-016 The first bit SHALL appear on sout, with sout_valid=1, in the cycle immediately after the accept edge (1-cycle latency); each later bit SHALL follow on each subsequent cycle, with no gaps.
REQ-017 Bit order SHALL follow MSB_FIRST; a bit counter SHALL count the WIDTH data bits, wrapping from WIDTH-1 to 0 at the end of each word.
REQ-018 busy SHALL be 1 in SHIFT and PARITY.
REQ-019 In SHIFT and PARITY, din_ready SHALL be 0 except during the final bit of the word, when it SHALL equal 1.
REQ-020 done SHALL be 1 exactly during the final bit of the word (the last data bit, or the parity bit when that feature is compiled in).
REQ-021 Final-bit transitions: on accept -> SHIFT with the new word's first bit on the next cycle, with no idle gap (back-to-back); otherwise -> IDLE.
REQ-022 din_valid asserted while din_ready=0 SHALL be ignored; din SHALL NOT disturb the word in flight.
REQ-023 All outputs SHALL be driven from registers or from the state register only, with no combinational path from din or din_valid.

Reset
REQ-024 While rst=0: state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, busy=0, done=0, din_ready=1 (held through reset).
REQ-025 Reset asserted mid-word SHALL abort the word immediately; after release, the block SHALL be in IDLE and no residual bits SHALL be emitted.

Configuration
REQ-026 Macro LZX_PISO_PARITY_EN: when defined, the block SHALL append one odd-parity bit (inverse of the XOR of all WIDTH data bits) in state PARITY after the last data bit, giving WIDTH+1 sout_valid cycles per word.
REQ-027 When LZX_PISO_PARITY_EN is undefined, the PARITY state and the parity logic SHALL be absent, giving WIDTH sout_valid cycles per word.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, macro undefined, accept din=8'hA5 -> sout over cycles 1..8 = 1,0,1,0,0,1,0,1; sout_valid=1 for exactly 8 cycles; done=1 in cycle 8 only; then IDLE with din_ready=1.
REQ-029 MSB_FIRST=0, din=8'h05 -> sout = 1,0,1,0,0,0,0,0; the detector downstream asserts its detect output once, after the third bit.
REQ-030 Back-to-back: din_valid held at 1 with 8'hFF then 8'h00 -> 16 consecutive sout_valid cycles, eight 1s then eight 0s; done pulses in cycles 8 and 16.
REQ-031 din_valid pulsed with 8'h00 during cycle 4 of word 8'hA5 -> ignored; the stream is unchanged.
REQ-032 rst pulled low in cycle 5 of a word -> sout=0, sout_valid=0, busy=0 asynchronously; after release, the next accepted word is sent intact from its first bit.
REQ-033 Macro defined, din=8'h07 -> 9 bits, parity bit 0; din=8'h03 -> parity bit 1; done coincides with the parity bit.
